// File: rtl/bcd_ascii_sender.sv
// Streams a captured 3-digit packed BCD value to a UART as ASCII characters,
// optionally dropping leading zeros and terminating the line with CR/LF.
module bcd_ascii_sender #(
    parameter bit SUPPRESS_ZEROS = 1'b1,
    parameter bit APPEND_CRLF    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] bcd_in,
    input  logic        send,
    input  logic        tx_busy,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    localparam logic [2:0] IDX_CR     = 3'd3;
    localparam logic [2:0] LAST_IDX   = APPEND_CRLF ? 3'd4 : 3'd2;
    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_BAD  = 8'h3F;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    state_t      state_reg, state_next;
    logic [2:0]  idx_reg, idx_next;
    logic [11:0] bcd_reg, bcd_next;
    logic [7:0]  tx_data_reg, tx_data_next;
    logic        tx_start_reg, tx_start_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;

    logic [2:0][7:0] digit_ascii;
    logic [2:0]      first_idx;
    logic [7:0]      cur_char;

    // Element 0 is the hundreds digit so it lines up with idx
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_digit
            logic [3:0] nib;
            assign nib             = bcd_reg[11 - 4*gi -: 4];
            assign digit_ascii[gi] = (nib <= 4'd9) ? (ASCII_ZERO + {4'd0, nib}) : ASCII_BAD;
        end
    endgenerate

    // Only leading zeros are skipped; the ones digit always goes out
    always_comb begin
        first_idx = 3'd0;
        if (SUPPRESS_ZEROS) begin
            if (bcd_in[11:8] != 4'd0)
                first_idx = 3'd0;
            else if (bcd_in[7:4] != 4'd0)
                first_idx = 3'd1;
            else
                first_idx = 3'd2;
        end
    end

    always_comb begin
        cur_char = ASCII_LF;
        case (idx_reg)
            3'd0:    cur_char = digit_ascii[0];
            3'd1:    cur_char = digit_ascii[1];
            3'd2:    cur_char = digit_ascii[2];
            IDX_CR:  cur_char = ASCII_CR;
            default: cur_char = ASCII_LF;
        endcase
    end

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        bcd_next      = bcd_reg;
        tx_data_next  = tx_data_reg;
        tx_start_next = 1'b0;
        busy_next     = busy_reg;
        done_next     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (send) begin
                    bcd_next   = bcd_in;
                    idx_next   = first_idx;
                    busy_next  = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (!tx_busy) begin
                    tx_data_next  = cur_char;
                    tx_start_next = 1'b1;
                    state_next    = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (tx_busy)
                    state_next = WAIT_LO;
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    if (idx_reg == LAST_IDX) begin
                        done_next  = 1'b1;
                        busy_next  = 1'b0;
                        state_next = IDLE;
                    end else begin
                        idx_next   = idx_reg + 3'd1;
                        state_next = ISSUE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            idx_reg      <= 3'd0;
            bcd_reg      <= 12'd0;
            tx_data_reg  <= 8'h00;
            tx_start_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            bcd_reg      <= bcd_next;
            tx_data_reg  <= tx_data_next;
            tx_start_reg <= tx_start_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
        end
    end

    assign tx_data  = tx_data_reg;
    assign tx_start = tx_start_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_bcd_ascii_sender.sv
// Bench for bcd_ascii_sender: default instance plus a no-suppression/no-CRLF
// instance, each driving a behavioural UART that records every launched byte.
module tb_bcd_ascii_sender;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [1:0][11:0] bcd_v;
    logic [1:0]       send_v;
    logic [1:0]       tx_busy_v;
    logic [1:0][7:0]  tx_data_v;
    logic [1:0]       tx_start_v;
    logic [1:0]       busy_v;
    logic [1:0]       done_v;

    bcd_ascii_sender dut (
        .clk(clk), .rst(rst), .bcd_in(bcd_v[0]), .send(send_v[0]),
        .tx_busy(tx_busy_v[0]), .tx_data(tx_data_v[0]), .tx_start(tx_start_v[0]),
        .busy(busy_v[0]), .done(done_v[0])
    );

    bcd_ascii_sender #(.SUPPRESS_ZEROS(1'b0), .APPEND_CRLF(1'b0)) dut_raw (
        .clk(clk), .rst(rst), .bcd_in(bcd_v[1]), .send(send_v[1]),
        .tx_busy(tx_busy_v[1]), .tx_data(tx_data_v[1]), .tx_start(tx_start_v[1]),
        .busy(busy_v[1]), .done(done_v[1])
    );

    // Behavioural UARTs: busy for len cycles after seeing tx_start, or while held
    int         cyc = 0;
    int         len0 = 10, len1 = 10;
    int         cnt0 = 0, cnt1 = 0;
    bit         hold0 = 1'b0;
    int         viol0 = 0, viol1 = 0;
    int         last0 = -100, gap0 = 0;
    logic [7:0] rx0[$];
    logic [7:0] rx1[$];
    logic [7:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;

    assign tx_busy_v[0] = (cnt0 != 0) || hold0;
    assign tx_busy_v[1] = (cnt1 != 0);

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (tx_start_v[0]) begin
            if (tx_busy_v[0]) viol0 <= viol0 + 1;
            rx0.push_back(tx_data_v[0]);
            cnt0  <= len0;
            gap0  <= cyc - last0;
            last0 <= cyc;
        end else if (cnt0 != 0) begin
            cnt0 <= cnt0 - 1;
        end
    end

    always @(posedge clk) begin
        if (tx_start_v[1]) begin
            if (tx_busy_v[1]) viol1 <= viol1 + 1;
            rx1.push_back(tx_data_v[1]);
            cnt1 <= len1;
        end else if (cnt1 != 0) begin
            cnt1 <= cnt1 - 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: the line a terminal should show for value v
    function automatic void build_expected(input logic [11:0] v, input bit sup, input bit crlf);
        int d [3];
        bit leading;
        exp_q.delete();
        d[0] = int'(v[11:8]);
        d[1] = int'(v[7:4]);
        d[2] = int'(v[3:0]);
        leading = sup;
        for (int i = 0; i < 3; i++) begin
            if (leading && d[i] == 0 && i < 2) continue;
            leading = 1'b0;
            exp_q.push_back(d[i] <= 9 ? 8'(48 + d[i]) : 8'h3F);
        end
        if (crlf) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endfunction

    function automatic int rx_size(input int inst);
        return (inst == 0) ? rx0.size() : rx1.size();
    endfunction

    function automatic logic [7:0] rx_at(input int inst, input int i);
        return (inst == 0) ? rx0[i] : rx1[i];
    endfunction

    // Called at a negedge: request a message and check acceptance timing
    task automatic start_msg(input int inst, input logic [11:0] v);
        if (inst == 0) rx0.delete(); else rx1.delete();
        bcd_v[inst]  = v;
        send_v[inst] = 1'b1;
        @(negedge clk);
        send_v[inst] = 1'b0;
        bcd_v[inst]  = 12'($urandom);
        check($sformatf("accept_busy %0d", inst), 32'(busy_v[inst]), 32'd1);
        check($sformatf("accept_done_low %0d", inst), 32'(done_v[inst]), 32'd0);
        if (!tx_busy_v[inst]) begin
            @(negedge clk);
            check($sformatf("first_tx_start %0d", inst), 32'(tx_start_v[inst]), 32'd1);
        end
    endtask

    // Waits for done (bounded), returns at the done negedge, compares bytes
    task automatic finish_msg(input int inst, input logic [11:0] v, input bit sup,
                              input bit crlf, input string tag);
        int n;
        n = 0;
        while (!done_v[inst] && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, " done"}, 32'(done_v[inst]), 32'd1);
        check({tag, " busy_fall"}, 32'(busy_v[inst]), 32'd0);
        build_expected(v, sup, crlf);
        check({tag, " nbytes"}, 32'(rx_size(inst)), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_size(inst); i++)
            check($sformatf("%s byte%0d", tag, i), 32'(rx_at(inst, i)), 32'(exp_q[i]));
        $display("msg %s bcd=%03h bytes=%0d", tag, v, rx_size(inst));
    endtask

    initial begin
        logic [11:0] v;
        int          n;
        int          sz;

        rst    = 1'b1;
        send_v = 2'b00;
        bcd_v  = '0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("reset tx_data %0d", k), 32'(tx_data_v[k]), 32'h00);
            check($sformatf("reset tx_start %0d", k), 32'(tx_start_v[k]), 32'd0);
            check($sformatf("reset busy %0d", k), 32'(busy_v[k]), 32'd0);
            check($sformatf("reset done %0d", k), 32'(done_v[k]), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Directed values on the default instance
        start_msg(0, 12'h255); finish_msg(0, 12'h255, 1'b1, 1'b1, "m255");
        start_msg(0, 12'h007); finish_msg(0, 12'h007, 1'b1, 1'b1, "m007");
        start_msg(0, 12'h000); finish_msg(0, 12'h000, 1'b1, 1'b1, "m000");
        start_msg(0, 12'h040); finish_msg(0, 12'h040, 1'b1, 1'b1, "m040");
        start_msg(0, 12'h1A3); finish_msg(0, 12'h1A3, 1'b1, 1'b1, "m1A3");
        @(negedge clk);
        check("done_one_cycle", 32'(done_v[0]), 32'd0);

        start_msg(1, 12'h009); finish_msg(1, 12'h009, 1'b0, 1'b0, "raw009");

        // New request while busy is ignored
        start_msg(0, 12'h321);
        repeat (20) @(negedge clk);
        bcd_v[0] = 12'h999; send_v[0] = 1'b1;
        @(negedge clk);
        send_v[0] = 1'b0;
        finish_msg(0, 12'h321, 1'b1, 1'b1, "ignore_send");

        // UART stalled for 50 cycles: no further launches
        start_msg(0, 12'h456);
        @(negedge clk);
        hold0 = 1'b1;
        sz = rx_size(0);
        repeat (50) @(negedge clk);
        check("stall no_start", 32'(rx_size(0)), 32'(sz));
        check("stall busy", 32'(busy_v[0]), 32'd1);
        hold0 = 1'b0;
        finish_msg(0, 12'h456, 1'b1, 1'b1, "stall");

        // Back-to-back: second request in the done cycle
        start_msg(0, 12'h100); finish_msg(0, 12'h100, 1'b1, 1'b1, "b2b_a");
        start_msg(0, 12'h089); finish_msg(0, 12'h089, 1'b1, 1'b1, "b2b_b");

        // One-cycle UART busy gives the minimum launch spacing
        len0 = 1;
        start_msg(0, 12'h255); finish_msg(0, 12'h255, 1'b1, 1'b1, "fast");
        check("min_spacing", 32'(gap0), 32'd4);
        len0 = 10;

        // Reset after the second byte, with send high at the same time
        start_msg(0, 12'h255);
        n = 0;
        while (rx_size(0) < 2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("rst second_byte", 32'(rx_size(0)), 32'd2);
        rst = 1'b1; send_v[0] = 1'b1; bcd_v[0] = 12'h777;
        @(negedge clk);
        check("rst tx_start", 32'(tx_start_v[0]), 32'd0);
        check("rst busy", 32'(busy_v[0]), 32'd0);
        check("rst tx_data", 32'(tx_data_v[0]), 32'h00);
        check("rst done", 32'(done_v[0]), 32'd0);
        rst = 1'b0; send_v[0] = 1'b0;
        @(negedge clk);
        check("rst wins_send", 32'(busy_v[0]), 32'd0);
        start_msg(0, 12'h128); finish_msg(0, 12'h128, 1'b1, 1'b1, "after_rst");

        // Randomised values and UART speeds
        for (int r = 0; r < 30; r++) begin
            for (int d = 0; d < 3; d++)
                v[d*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            len0 = $urandom_range(1, 12);
            start_msg(0, v);
            finish_msg(0, v, 1'b1, 1'b1, $sformatf("rnd%0d", r));
        end
        for (int r = 0; r < 8; r++) begin
            v = 12'($urandom);
            len1 = $urandom_range(1, 12);
            start_msg(1, v);
            finish_msg(1, v, 1'b0, 1'b0, $sformatf("rawrnd%0d", r));
        end

        @(negedge clk);
        check("handshake_viol0", 32'(viol0), 32'd0);
        check("handshake_viol1", 32'(viol1), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_ascii_sender.md
# bcd_ascii_sender

Downstream stage of the 8-bit binary-to-BCD converter. It captures a 3-digit packed BCD value (hundreds, tens, ones), converts each digit to ASCII, and feeds the characters one byte at a time to the UART transmitter using a start/busy handshake. Optional leading-zero suppression and a CR/LF terminator make each value print as one readable line on a serial terminal.

## Interface
Parameters:
- `SUPPRESS_ZEROS`, default 1: when 1, leading zero digits are not sent. The ones digit is always sent.
- `APPEND_CRLF`, default 1: when 1, 0x0D then 0x0A are sent after the ones digit.

Ports:
- `clk` input 1: single clock; all logic is rising-edge.
- `rst` input 1: synchronous, active-high reset.
- `bcd_in` input 12: packed BCD value. [11:8] is hundreds, [7:4] is tens, [3:0] is ones.
- `send` input 1: request to transmit `bcd_in`. Sampled only in IDLE.
- `tx_busy` input 1: UART transmitter busy flag.
- `tx_data` output 8: ASCII byte presented to the UART. Registered.
- `tx_start` output 1: one-cycle pulse that launches `tx_data`. Registered.
- `busy` output 1: high from acceptance of `send` until the message completes.
- `done` output 1: one-cycle pulse when the last byte has completed.

## Operation
- States:
  - IDLE: waits for `send`.
  - ISSUE: launches the current character.
  - WAIT_HI: waits for the UART to report busy.
  - WAIT_LO: waits for the UART to finish the byte.
- Character index `idx` runs 0..4: 0 = hundreds, 1 = tens, 2 = ones, 3 = CR, 4 = LF.
- Last index is 4 when `APPEND_CRLF=1`, else 2.
- IDLE with `send`=1:
  - Latch `bcd_in`.
  - Set `busy`=1 and go to ISSUE.
  - Set the start `idx`:
    - `SUPPRESS_ZEROS=0`: 0.
    - Otherwise, 0 if hundreds≠0; else 1 if tens≠0; else 2.
  - Suppression tests for digit==0 only. A zero that follows a nonzero digit is always sent.
- ISSUE with `tx_busy`=0:
  - `tx_data` ← character for `idx`. `tx_start` ← 1 for one cycle.
  - Go to WAIT_HI.
- ISSUE with `tx_busy`=1: hold; nothing is asserted.
- Digit encoding:
  - 0–9 map to 0x30 + digit.
  - Values 0xA–0xF map to 0x3F ('?').
  - CR = 0x0D, LF = 0x0A.
- WAIT_HI: on `tx_busy`=1, go to WAIT_LO. The UART contract is that `tx_busy` rises within one cycle of `tx_start`; the FSM waits indefinitely.
- WAIT_LO with `tx_busy`=0:
  - If `idx` = last: `done` ← 1, `busy` ← 0, go to IDLE.
  - Otherwise: `idx` ← `idx`+1, go to ISSUE.
- `send` is ignored outside IDLE; there is no queuing.
- `bcd_in` changes after capture have no effect on the message in progress.
- `tx_data` holds its last value between launches.

## Timing
- Reset values: `tx_data`=0x00, `tx_start`=0, `busy`=0, `done`=0, state IDLE, `idx`=0.
- A `send` sampled at edge k gives:
  - `busy`=1 after edge k.
  - First `tx_start` high after edge k+1, provided `tx_busy`=0.
- `tx_start` is high for exactly one cycle per character and is never reasserted until `tx_busy` has gone high and then low.
- Minimum spacing between two `tx_start` pulses is 4 cycles (UART busy for 1 cycle).
- `done` goes high on the same edge that `busy` falls, and lasts one cycle.
- `send` is accepted in the cycle `done` is high, because the state is already IDLE. Back-to-back messages are allowed.
- `rst` asserted mid-message: all outputs take reset values at the next edge and the message is abandoned. A byte already launched completes inside the UART. The next `send` starts a fresh message.
- `rst` and `send` high together: reset wins.

## Test plan
- `bcd_in`=0x255, defaults, `tx_busy` modelling 10 cycles per byte → bytes 0x32, 0x35, 0x35, 0x0D, 0x0A. Exactly 5 `tx_start` pulses and one `done`.
- Leading-zero suppression, defaults:
  - `bcd_in`=0x007 → 0x37, 0x0D, 0x0A.
  - `bcd_in`=0x000 → 0x30, 0x0D, 0x0A.
  - `bcd_in`=0x040 → 0x34, 0x30, 0x0D, 0x0A.
- `SUPPRESS_ZEROS=0`, `APPEND_CRLF=0`, `bcd_in`=0x009 → 0x30, 0x30, 0x39, then `done`. No CR/LF.
- Invalid digit: `bcd_in`=0x1A3 → 0x31, 0x3F, 0x33, 0x0D, 0x0A.
- Handshake and ignored requests:
  - Pulse `send` with a new value while `busy`=1 → ignored and the original message completes.
  - Hold `tx_busy`=1 for 50 cycles → FSM stalls with no extra `tx_start`.
  - Second `send` in the `done` cycle → accepted.
- `rst` pulse after the 2nd byte of 0x255:
  - Next edge: `tx_start`=0, `busy`=0, `tx_data`=0x00, `done`=0.
  - A subsequent `send` of 0x128 → 0x31, 0x32, 0x38, 0x0D, 0x0A.
